// File: rtl/mips_monitor_pkg.sv
// Shared types and default addresses for the MIPS halt monitor.
package mips_monitor_pkg;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_RUN,
        MON_SETTLE,
        MON_DONE
    } mon_state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;

endpackage

// File: rtl/mips_halt_monitor_if.sv
// CPU observation inputs and result outputs of the halt monitor.
interface mips_halt_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             clk_enable;
    logic             active;
    logic [31:0]      instr_address;
    logic [31:0]      register_v0;
    logic             check_en;
    logic [31:0]      expected_v0;

    logic             running;
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [31:0]      halt_v0;
    logic [CNT_W-1:0] cycle_count;

    // Side that drives the CPU signals and reads results.
    modport master (
        output clk_enable, active, instr_address, register_v0, check_en, expected_v0,
        input  running, done, pass, fail, timeout, halt_v0, cycle_count
    );

    // The monitor itself.
    modport slave (
        input  clk_enable, active, instr_address, register_v0, check_en, expected_v0,
        output running, done, pass, fail, timeout, halt_v0, cycle_count
    );
endinterface

// File: rtl/mips_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module mips_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Clear wins over increment; increment stops at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mips_halt_monitor.sv
// Watches CPU fetches for start/halt, captures and checks $v0, counts run cycles.
module mips_halt_monitor
    import mips_monitor_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = RESET_VECTOR_DEF,
    parameter logic [31:0] HALT_ADDR      = HALT_ADDR_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input logic                clk,
    input logic                reset,
    mips_halt_monitor_if.slave mon
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_t       state_q, state_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      halt_v0_q, halt_v0_d;
    logic             cnt_en, cnt_clr;
    logic [CNT_W-1:0] cnt;
    logic             start_hit, halt_hit, timeout_hit, mismatch;

    assign start_hit   = mon.active && (mon.instr_address == RESET_VECTOR);
    assign halt_hit    = !mon.active || (mon.instr_address == HALT_ADDR);
    assign timeout_hit = (cnt == LAST_CNT);
    assign mismatch    = (mon.register_v0 != mon.expected_v0);

    mips_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .count (cnt)
    );

    // Next-state and result logic; nothing moves without clk_enable.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        halt_v0_d = halt_v0_q;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        if (mon.clk_enable) begin
            unique case (state_q)
                MON_IDLE: begin
                    if (start_hit) begin
                        state_d = MON_RUN;
                        cnt_clr = 1'b1;
                    end
                end
                MON_RUN: begin
                    // Halt beats timeout; the timeout edge itself leaves the count at LAST_CNT.
                    if (halt_hit) begin
                        state_d = MON_SETTLE;
                        cnt_en  = 1'b1;
                    end else if (timeout_hit) begin
                        state_d   = MON_DONE;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                MON_SETTLE: begin
                    halt_v0_d = mon.register_v0;
                    if (mon.check_en) begin
                        fail_d = mismatch;
                        pass_d = !mismatch;
                    end else begin
                        pass_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = MON_DONE;
                end
                MON_DONE: begin
                end
                default: begin
                    state_d = MON_IDLE;
                end
            endcase
        end
    end

    assign running_d = (state_d == MON_RUN) || (state_d == MON_SETTLE);

    // State and result registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MON_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            halt_v0_q <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            halt_v0_q <= halt_v0_d;
        end
    end

    assign mon.running     = running_q;
    assign mon.done        = done_q;
    assign mon.pass        = pass_q;
    assign mon.fail        = fail_q;
    assign mon.timeout     = timeout_q;
    assign mon.halt_v0     = halt_v0_q;
    assign mon.cycle_count = cnt;

endmodule

// File: tb/tb_mips_halt_monitor.sv
// Directed bench for mips_halt_monitor with TIMEOUT_CYCLES=20.
module tb_mips_halt_monitor;
    import mips_monitor_pkg::*;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TO    = 20;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mips_halt_monitor_if #(.CNT_W(CNT_W)) mon ();

    mips_halt_monitor #(
        .RESET_VECTOR   (RESET_VECTOR_DEF),
        .HALT_ADDR      (HALT_ADDR_DEF),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        mon.instr_address = a;
        tick();
    endtask

    task automatic do_reset();
        mon.clk_enable    = 1'b1;
        mon.active        = 1'b1;
        mon.instr_address = 32'hDEAD_0000;
        mon.register_v0   = 32'h0;
        mon.check_en      = 1'b1;
        mon.expected_v0   = 32'h1;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Start fetch plus four program fetches; sltiu leaves v0=1. Count ends at 4.
    task automatic drive_prog();
        fetch(32'hBFC0_0000);
        fetch(32'hBFC0_0004);
        fetch(32'hBFC0_0008);
        mon.register_v0 = 32'h1;
        fetch(32'hBFC0_000C);
        fetch(32'hBFC0_0010);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++;
        if ({mon.running, mon.done, mon.pass, mon.fail, mon.timeout, mon.halt_v0,
             mon.cycle_count} !== '0)
            begin errors++; $display("FAIL reset_outputs got run=%0b done=%0b cnt=%0d v0=%h want all 0",
                mon.running, mon.done, mon.cycle_count, mon.halt_v0); end
        do_reset();
        mon.active = 1'b0;
        fetch(32'hBFC0_0000);
        checks++;
        if (mon.running !== 1'b0)
            begin errors++; $display("FAIL idle_inactive_start got running=%0b want 0", mon.running); end
    endtask

    task automatic test_pass();
        do_reset();
        drive_prog();
        checks++;
        if (mon.running !== 1'b1 || mon.cycle_count !== 16'd4)
            begin errors++; $display("FAIL pass_midrun got run=%0b cnt=%0d want run=1 cnt=4",
                mon.running, mon.cycle_count); end
        fetch(32'h0000_0000);
        checks++;
        if (mon.done !== 1'b0 || mon.running !== 1'b1 || mon.cycle_count !== 16'd5)
            begin errors++; $display("FAIL pass_settle got done=%0b run=%0b cnt=%0d want 0 1 5",
                mon.done, mon.running, mon.cycle_count); end
        tick();
        checks++;
        if ({mon.done, mon.pass, mon.fail, mon.timeout, mon.running} !== 5'b11000)
            begin errors++; $display("FAIL pass_flags got d/p/f/t/r=%b want 11000",
                {mon.done, mon.pass, mon.fail, mon.timeout, mon.running}); end
        checks++;
        if (mon.halt_v0 !== 32'h1 || mon.cycle_count !== 16'd5)
            begin errors++; $display("FAIL pass_v0_cnt got v0=%h cnt=%0d want 1 5",
                mon.halt_v0, mon.cycle_count); end
        fetch(32'hBFC0_0000);
        fetch(32'hBFC0_0004);
        checks++;
        if (mon.running !== 1'b0 || mon.done !== 1'b1 || mon.cycle_count !== 16'd5)
            begin errors++; $display("FAIL done_sticky got run=%0b done=%0b cnt=%0d want 0 1 5",
                mon.running, mon.done, mon.cycle_count); end
    endtask

    task automatic test_fail();
        do_reset();
        mon.expected_v0 = 32'h2;
        drive_prog();
        fetch(32'h0000_0000);
        tick();
        checks++;
        if ({mon.done, mon.pass, mon.fail, mon.timeout} !== 4'b1010 || mon.halt_v0 !== 32'h1)
            begin errors++; $display("FAIL fail_flags got d/p/f/t=%b v0=%h want 1010 v0=1",
                {mon.done, mon.pass, mon.fail, mon.timeout}, mon.halt_v0); end
    endtask

    task automatic test_timeout();
        do_reset();
        fetch(32'hBFC0_0000);
        for (int i = 0; i < 19; i++) fetch(32'hBFC0_0004);
        checks++;
        if (mon.cycle_count !== 16'd19 || mon.timeout !== 1'b0 || mon.running !== 1'b1)
            begin errors++; $display("FAIL timeout_pre got cnt=%0d to=%0b run=%0b want 19 0 1",
                mon.cycle_count, mon.timeout, mon.running); end
        fetch(32'hBFC0_0004);
        checks++;
        if ({mon.done, mon.pass, mon.fail, mon.timeout, mon.running} !== 5'b10010)
            begin errors++; $display("FAIL timeout_flags got d/p/f/t/r=%b want 10010",
                {mon.done, mon.pass, mon.fail, mon.timeout, mon.running}); end
        checks++;
        if (mon.cycle_count !== 16'd19)
            begin errors++; $display("FAIL timeout_cnt got %0d want 19", mon.cycle_count); end
    endtask

    task automatic test_clk_enable();
        do_reset();
        mon.register_v0 = 32'h1;
        fetch(32'hBFC0_0000);
        for (int i = 0; i < 3; i++) fetch(32'hBFC0_0004);
        mon.clk_enable = 1'b0;
        mon.active     = 1'b0;
        for (int i = 0; i < 5; i++) fetch(32'h0000_0000);
        checks++;
        if (mon.cycle_count !== 16'd3 || mon.running !== 1'b1 || mon.done !== 1'b0)
            begin errors++; $display("FAIL ce_frozen got cnt=%0d run=%0b done=%0b want 3 1 0",
                mon.cycle_count, mon.running, mon.done); end
        mon.clk_enable = 1'b1;
        mon.active     = 1'b1;
        fetch(32'hBFC0_0008);
        fetch(32'hBFC0_000C);
        fetch(32'h0000_0000);
        tick();
        checks++;
        if (mon.pass !== 1'b1 || mon.cycle_count !== 16'd6)
            begin errors++; $display("FAIL ce_resume got pass=%0b cnt=%0d want 1 6",
                mon.pass, mon.cycle_count); end
    endtask

    task automatic test_active_halt();
        do_reset();
        mon.check_en    = 1'b0;
        mon.expected_v0 = 32'h5;
        mon.register_v0 = 32'hFFFF_FFFE;
        fetch(32'hBFC0_0000);
        fetch(32'hBFC0_0004);
        mon.active = 1'b0;
        fetch(32'hBFC0_0008);
        checks++;
        if (mon.running !== 1'b1 || mon.done !== 1'b0 || mon.cycle_count !== 16'd2)
            begin errors++; $display("FAIL inactive_settle got run=%0b done=%0b cnt=%0d want 1 0 2",
                mon.running, mon.done, mon.cycle_count); end
        tick();
        checks++;
        if ({mon.done, mon.pass, mon.fail} !== 3'b110 || mon.halt_v0 !== 32'hFFFF_FFFE)
            begin errors++; $display("FAIL nocheck_pass got d/p/f=%b v0=%h want 110 fffffffe",
                {mon.done, mon.pass, mon.fail}, mon.halt_v0); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        fetch(32'hBFC0_0000);
        for (int i = 0; i < 3; i++) fetch(32'hBFC0_0004);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({mon.running, mon.done, mon.pass, mon.fail, mon.timeout, mon.halt_v0,
             mon.cycle_count} !== '0)
            begin errors++; $display("FAIL async_reset got run=%0b cnt=%0d want 0 0",
                mon.running, mon.cycle_count); end
        tick();
        reset = 1'b1;
        mon.register_v0 = 32'h0;
        drive_prog();
        fetch(32'h0000_0000);
        tick();
        checks++;
        if (mon.pass !== 1'b1 || mon.cycle_count !== 16'd5 || mon.halt_v0 !== 32'h1)
            begin errors++; $display("FAIL rerun_pass got pass=%0b cnt=%0d v0=%h want 1 5 1",
                mon.pass, mon.cycle_count, mon.halt_v0); end
    endtask

    task automatic test_halt_timeout_same();
        do_reset();
        mon.register_v0 = 32'h1;
        fetch(32'hBFC0_0000);
        for (int i = 0; i < 19; i++) fetch(32'hBFC0_0004);
        fetch(32'h0000_0000);
        checks++;
        if (mon.running !== 1'b1 || mon.timeout !== 1'b0 || mon.cycle_count !== 16'd20)
            begin errors++; $display("FAIL tie_settle got run=%0b to=%0b cnt=%0d want 1 0 20",
                mon.running, mon.timeout, mon.cycle_count); end
        tick();
        checks++;
        if ({mon.done, mon.pass, mon.fail, mon.timeout} !== 4'b1100)
            begin errors++; $display("FAIL tie_flags got d/p/f/t=%b want 1100",
                {mon.done, mon.pass, mon.fail, mon.timeout}); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_clk_enable();
        test_active_halt();
        test_reset_midrun();
        test_halt_timeout_same();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
